// File: rtl/hazard_ctrl_unit.sv
// Hazard, forwarding and multi-cycle stall controller for the 5-stage RV32 pipeline.
// Drives stage-register stall/flush enables, E-stage operand forwarding and perf counters.
module hazard_ctrl_unit #(
  parameter int REG_AW     = 5,
  parameter int MUL_LAT    = 3,
  parameter int FORWARD_EN = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic              RegWriteE,
  input  logic [1:0]        ResultSrcE,
  input  logic              MulOpE,
  input  logic              PCSrcE,
  input  logic [REG_AW-1:0] RdM,
  input  logic              RegWriteM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteW,
  input  logic              CntClr,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MulBusy,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  RedirectCount
);

  localparam int CW = $clog2(MUL_LAT) + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [CW-1:0]    LAST_CNT = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CNT_W-1:0] PERF_ONE = CNT_W'(1);
  localparam bit               MULTI    = (MUL_LAT > 1);
  localparam bit               FWD      = (FORWARD_EN != 0);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // x0 is hard-wired zero, so a reference to it is never a dependency.
  function automatic logic regMatch(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  logic [0:0]    state;
  logic [0:0]    stateNext;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cntNext;

  logic loadE;
  logic lwStall;
  logic dataStall;
  logic hzStall;
  logic mulStall;
  logic depOnE;
  logic depOnM;

  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (FWD) begin
      if (RegWriteM && regMatch(RdM, Rs1E))      ForwardAE = FWD_MEM;
      else if (RegWriteW && regMatch(RdW, Rs1E)) ForwardAE = FWD_WB;
      if (RegWriteM && regMatch(RdM, Rs2E))      ForwardBE = FWD_MEM;
      else if (RegWriteW && regMatch(RdW, Rs2E)) ForwardBE = FWD_WB;
    end
  end

  assign loadE  = (ResultSrcE == 2'b01);
  assign depOnE = regMatch(RdE, Rs1D) || regMatch(RdE, Rs2D);
  assign depOnM = regMatch(RdM, Rs1D) || regMatch(RdM, Rs2D);

  // Without forwarding, any producer still in E or M must drain first; W is write-through.
  assign lwStall   = FWD && loadE && depOnE;
  assign dataStall = !FWD && ((RegWriteE && depOnE) || (RegWriteM && depOnM));
  assign hzStall   = lwStall || dataStall;

  assign mulStall = MulOpE && ((state == IDLE) ? MULTI : (cnt < LAST_CNT));
  assign MulBusy  = (state == BUSY);

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: begin
        if (MulOpE && MULTI) begin
          stateNext = BUSY;
          cntNext   = CNT_ONE;
        end
      end
      BUSY: begin
        if (MulOpE && mulStall) begin
          cntNext = cnt + CNT_ONE;
        end else begin
          // Either the op completes this cycle or it was flushed out of E.
          stateNext = IDLE;
          cntNext   = '0;
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // A busy execute unit freezes everything; a redirect beats a data hazard so the PC takes the target.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (mulStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (hzStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCount    <= '0;
      RedirectCount <= '0;
    end else if (CntClr) begin
      StallCount    <= '0;
      RedirectCount <= '0;
    end else begin
      if (StallD && (StallCount != '1))
        StallCount <= StallCount + PERF_ONE;
      if (PCSrcE && !mulStall && (RedirectCount != '1))
        RedirectCount <= RedirectCount + PERF_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench: instance A forwards (16-bit counters), instance B has no forwarding and 2-bit counters.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic [1:0] ResultSrcE;
  logic       MulOpE, PCSrcE, CntClr;

  logic        aStallF, aStallD, aStallE, aFlushD, aFlushE, aFlushM, aMulBusy;
  logic [1:0]  aFwdA, aFwdB;
  logic [15:0] aStallCount, aRedirectCount;

  logic        bStallF, bStallD, bStallE, bFlushD, bFlushE, bFlushM, bMulBusy;
  logic [1:0]  bFwdA, bFwdB;
  logic [1:0]  bStallCount, bRedirectCount;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_AW(5), .MUL_LAT(3), .FORWARD_EN(1), .CNT_W(16)) dutA (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MulOpE(MulOpE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW), .CntClr(CntClr),
    .StallF(aStallF), .StallD(aStallD), .StallE(aStallE), .FlushD(aFlushD), .FlushE(aFlushE),
    .FlushM(aFlushM), .ForwardAE(aFwdA), .ForwardBE(aFwdB), .MulBusy(aMulBusy),
    .StallCount(aStallCount), .RedirectCount(aRedirectCount)
  );

  hazard_ctrl_unit #(.REG_AW(5), .MUL_LAT(3), .FORWARD_EN(0), .CNT_W(2)) dutB (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MulOpE(MulOpE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW), .CntClr(CntClr),
    .StallF(bStallF), .StallD(bStallD), .StallE(bStallE), .FlushD(bFlushD), .FlushE(bFlushE),
    .FlushM(bFlushM), .ForwardAE(bFwdA), .ForwardBE(bFwdB), .MulBusy(bMulBusy),
    .StallCount(bStallCount), .RedirectCount(bRedirectCount)
  );

  // Control vector order: StallF StallD StallE FlushD FlushE FlushM
  function automatic logic [5:0] ctlA();
    return {aStallF, aStallD, aStallE, aFlushD, aFlushE, aFlushM};
  endfunction
  function automatic logic [5:0] ctlB();
    return {bStallF, bStallD, bStallE, bFlushD, bFlushE, bFlushM};
  endfunction

  task automatic clearInputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    ResultSrcE = 2'b00; MulOpE = 1'b0; PCSrcE = 1'b0; CntClr = 1'b0;
  endtask

  // Advance one edge; inputs are then driven and sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clearInputs();
    #2;
    nChecks++;
    if ({ctlA(), aFwdA, aFwdB, aMulBusy} !== 11'b0) begin
      nErrors++;
      $display("FAIL reset_outs_a: got %b want 0", {ctlA(), aFwdA, aFwdB, aMulBusy});
    end
    nChecks++;
    if ({aStallCount, aRedirectCount, bStallCount, bRedirectCount} !== 36'b0) begin
      nErrors++;
      $display("FAIL reset_counters: got %h/%h/%h/%h want 0", aStallCount, aRedirectCount, bStallCount, bRedirectCount);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_forwarding();
    clearInputs();
    RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5; Rs2E = 5'd5;
    #1;
    nChecks++;
    if ({aFwdA, aFwdB} !== 4'b1010) begin
      nErrors++;
      $display("FAIL fwd_m_priority: got %b want 1010", {aFwdA, aFwdB});
    end
    nChecks++;
    if ({bFwdA, bFwdB} !== 4'b0000) begin
      nErrors++;
      $display("FAIL fwd_disabled: got %b want 0000", {bFwdA, bFwdB});
    end
    RegWriteM = 1'b0;
    #1;
    nChecks++;
    if (aFwdA !== 2'b01) begin
      nErrors++;
      $display("FAIL fwd_w: got %b want 01", aFwdA);
    end
    Rs1E = 5'd0; RdM = 5'd0; RdW = 5'd0; RegWriteM = 1'b1; Rs2E = 5'd9;
    #1;
    nChecks++;
    if ({aFwdA, aFwdB} !== 4'b0000) begin
      nErrors++;
      $display("FAIL fwd_x0: got %b want 0000", {aFwdA, aFwdB});
    end
    tick();
    clearInputs();
  endtask

  task automatic test_load_use();
    clearInputs();
    ResultSrcE = 2'b01; RdE = 5'd0; Rs1D = 5'd0;
    #1;
    nChecks++;
    if (ctlA() !== 6'b000000) begin
      nErrors++;
      $display("FAIL lw_x0: got %b want 000000", ctlA());
    end
    RdE = 5'd7; Rs2D = 5'd7;
    #1;
    nChecks++;
    if (ctlA() !== 6'b110010) begin
      nErrors++;
      $display("FAIL lw_stall: got %b want 110010", ctlA());
    end
    nChecks++;
    if (ctlB() !== 6'b000000) begin
      nErrors++;
      $display("FAIL lw_nofwd_gate: got %b want 000000", ctlB());
    end
    tick();
    clearInputs();
    #1;
    nChecks++;
    if (aStallCount !== 16'd1 || bStallCount !== 2'd0) begin
      nErrors++;
      $display("FAIL lw_stall_count: got a=%0d b=%0d want a=1 b=0", aStallCount, bStallCount);
    end
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7; PCSrcE = 1'b1;
    #1;
    nChecks++;
    if (ctlA() !== 6'b000110) begin
      nErrors++;
      $display("FAIL redirect_prio: got %b want 000110", ctlA());
    end
    tick();
    clearInputs();
    #1;
    nChecks++;
    if (aRedirectCount !== 16'd1 || bRedirectCount !== 2'd1 || aStallCount !== 16'd1) begin
      nErrors++;
      $display("FAIL redirect_count: got a=%0d b=%0d astall=%0d want 1 1 1", aRedirectCount, bRedirectCount, aStallCount);
    end
  endtask

  task automatic test_mul();
    // Expected StallE per cycle over two back-to-back ops, plus MulBusy.
    logic [5:0] expStall = 6'b110110;
    logic [5:0] expBusy  = 6'b011011;
    clearInputs();
    MulOpE = 1'b1;
    for (int c = 0; c < 6; c++) begin
      PCSrcE = (c == 1);
      #1;
      nChecks++;
      if ({aStallE, aFlushM, aStallF, aFlushD} !== {expStall[5-c], expStall[5-c], expStall[5-c], 1'b0} ||
          aMulBusy !== expBusy[5-c]) begin
        nErrors++;
        $display("FAIL mul_cycle%0d: got stallE=%b flushM=%b stallF=%b flushD=%b busy=%b want stall=%b busy=%b",
                 c + 1, aStallE, aFlushM, aStallF, aFlushD, aMulBusy, expStall[5-c], expBusy[5-c]);
      end
      nChecks++;
      if (bStallE !== expStall[5-c] || bMulBusy !== expBusy[5-c]) begin
        nErrors++;
        $display("FAIL mul_b_cycle%0d: got stallE=%b busy=%b want %b %b", c + 1, bStallE, bMulBusy, expStall[5-c], expBusy[5-c]);
      end
      tick();
    end
    clearInputs();
    #1;
    nChecks++;
    if (aMulBusy !== 1'b0 || ctlA() !== 6'b0) begin
      nErrors++;
      $display("FAIL mul_done: got busy=%b ctl=%b want 0", aMulBusy, ctlA());
    end
    nChecks++;
    if (aStallCount !== 16'd5 || bStallCount !== 2'd3 || aRedirectCount !== 16'd1 || bRedirectCount !== 2'd1) begin
      nErrors++;
      $display("FAIL mul_counters: got as=%0d bs=%0d ar=%0d br=%0d want 5 3 1 1",
               aStallCount, bStallCount, aRedirectCount, bRedirectCount);
    end
    CntClr = 1'b1;
    tick();
    CntClr = 1'b0;
    #1;
    nChecks++;
    if ({aStallCount, aRedirectCount, bStallCount, bRedirectCount} !== 36'b0) begin
      nErrors++;
      $display("FAIL cnt_clr: got %0d %0d %0d %0d want 0", aStallCount, aRedirectCount, bStallCount, bRedirectCount);
    end
  endtask

  task automatic test_no_forward();
    logic [1:0] expCnt;
    clearInputs();
    RdM = 5'd3; RegWriteM = 1'b1; Rs1D = 5'd3;
    for (int k = 1; k <= 5; k++) begin
      #1;
      nChecks++;
      if (ctlB() !== 6'b110010 || bFwdA !== 2'b00 || ctlA() !== 6'b0) begin
        nErrors++;
        $display("FAIL nofwd_stall_%0d: got b=%b fwd=%b a=%b want 110010 00 000000", k, ctlB(), bFwdA, ctlA());
      end
      tick();
      expCnt = (k >= 3) ? 2'd3 : 2'(k);
      nChecks++;
      if (bStallCount !== expCnt || aStallCount !== 16'd0) begin
        nErrors++;
        $display("FAIL sat_count_%0d: got b=%0d a=%0d want b=%0d a=0", k, bStallCount, aStallCount, expCnt);
      end
    end
    RdM = 5'd0; RegWriteM = 1'b0; RdW = 5'd3; RegWriteW = 1'b1; Rs1E = 5'd3;
    #1;
    nChecks++;
    if (ctlB() !== 6'b0 || bFwdA !== 2'b00 || aFwdA !== 2'b01) begin
      nErrors++;
      $display("FAIL nofwd_w: got b=%b bfwd=%b afwd=%b want 000000 00 01", ctlB(), bFwdA, aFwdA);
    end
    CntClr = 1'b1;
    tick();
    clearInputs();
    #1;
    nChecks++;
    if (bStallCount !== 2'd0) begin
      nErrors++;
      $display("FAIL sat_clear: got %0d want 0", bStallCount);
    end
  endtask

  task automatic test_reset_busy();
    clearInputs();
    MulOpE = 1'b1;
    tick();
    nChecks++;
    if (aMulBusy !== 1'b1 || aStallE !== 1'b1) begin
      nErrors++;
      $display("FAIL busy_before_rst: got busy=%b stallE=%b want 1 1", aMulBusy, aStallE);
    end
    #2;
    rst = 1'b1;
    MulOpE = 1'b0;
    #1;
    nChecks++;
    if (aMulBusy !== 1'b0 || ctlA() !== 6'b0 || bMulBusy !== 1'b0) begin
      nErrors++;
      $display("FAIL rst_midbusy: got busy=%b ctl=%b bbusy=%b want 0", aMulBusy, ctlA(), bMulBusy);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      nChecks++;
      if (aMulBusy !== 1'b0 || ctlA() !== 6'b0 || aStallCount !== 16'd0) begin
        nErrors++;
        $display("FAIL post_rst_%0d: got busy=%b ctl=%b cnt=%0d want 0", k, aMulBusy, ctlA(), aStallCount);
      end
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_mul();
    test_no_forward();
    test_reset_busy();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised hazard, forwarding and multi-cycle-stall controller for the 5-stage pipelined RV32 core (F/D/E/M/W). It replaces the fixed-function forwarding unit. It adds load-use stalls, taken-branch flushes, a selectable no-forwarding mode, and a registered stall sequencer for a multi-cycle execute unit of configurable latency. It also provides saturating stall and redirect performance counters. It sits beside the stage registers and drives their stall and flush enables.

## Interface
- REG_AW, 5: register address width; 4 for RV32E.
- MUL_LAT, 3: cycles a multi-cycle op occupies E, ≥1; 1 means no stall.
- FORWARD_EN, 1: 1 selects M/W→E forwarding; 0 means no forwarding, and hazards are resolved by stalling.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- Rs1D, Rs2D  in  REG_AW  source registers in D.
- Rs1E, Rs2E, RdE  in  REG_AW  source and destination registers in E.
- RegWriteE  in  1  E writes the register file.
- ResultSrcE  in  2  E result select; 2'b01 means load.
- MulOpE  in  1  multi-cycle op present in E (level).
- PCSrcE  in  1  taken branch/jump resolved in E.
- RdM, RegWriteM  in  REG_AW, 1  M destination register and write enable.
- RdW, RegWriteW  in  REG_AW, 1  W destination register and write enable.
- CntClr  in  1  synchronous clear of both counters.
- StallF, StallD, StallE  out  1  hold PC / D-reg / E-reg.
- FlushD, FlushE, FlushM  out  1  bubble into D-reg / E-reg / M-reg.
- ForwardAE, ForwardBE  out  2  00 = register file, 01 = ResultW, 10 = ALUResultM.
- MulBusy  out  1  sequencer in BUSY.
- StallCount, RedirectCount  out  CNT_W  performance counters.

## Operation
- Register x0 never matches: any compare against address 0 is false.
- Forwarding (FORWARD_EN=1), per operand:
  - ForwardAE = 10 if RegWriteM & RdM==Rs1E.
  - Otherwise 01 if RegWriteW & RdW==Rs1E.
  - Otherwise 00.
  - ForwardBE is the same using Rs2E. M has priority over W.
- FORWARD_EN=0: ForwardAE and ForwardBE are tied to 00.
- dataStall (FORWARD_EN=0 only) = Rs1D or Rs2D matches RdE with RegWriteE, or matches RdM with RegWriteM. W needs no stall because the register file is write-through.
- lwStall (FORWARD_EN=1 only) = ResultSrcE==01 & RdE matches Rs1D or Rs2D.
- hzStall = lwStall | dataStall.
- Multi-cycle sequencer, states IDLE and BUSY, with counter cnt of width clog2(MUL_LAT)+1:
  - mulStall = MulOpE & (IDLE ? MUL_LAT>1 : cnt < MUL_LAT-1).
  - IDLE → BUSY when MulOpE & MUL_LAT>1; cnt ← 1.
  - BUSY: cnt ← cnt+1 while mulStall. When mulStall=0, the op leaves E at the next edge; state → IDLE and cnt ← 0.
  - MulBusy = (state==BUSY).
  - If MulOpE drops while in BUSY (external flush): → IDLE, cnt ← 0.
- Output priority, highest first:
  1. mulStall: StallF=StallD=StallE=1, FlushM=1, FlushD=FlushE=0.
  2. PCSrcE: FlushD=FlushE=1, all stalls 0. The redirect wins over hzStall so that the PC takes the target.
  3. hzStall: StallF=StallD=1, FlushE=1.
  4. Otherwise: all 0.
- StallCount increments (saturating at all-ones) each cycle StallD=1.
- RedirectCount increments (saturating) each cycle PCSrcE=1 and mulStall=0.
- CntClr sets both counters to 0 and takes priority over increment.

## Timing
- Stall, flush and forward outputs are combinational from the inputs and state, with zero latency. They must settle within the cycle they apply to.
- State, cnt and the counters update on the rising clk edge.
- Reset (async assert):
  - state=IDLE, cnt=0, both counters 0.
  - With inputs idle, all stall/flush outputs are 0, forwards are 00 and MulBusy=0.
- A MUL_LAT=N op holds E for exactly N cycles. The stall is asserted for N-1 of them.
- Back-to-back multi-cycle ops restart from IDLE with no gap cycle.
- Reset asserted mid-BUSY returns the sequencer to IDLE immediately. No stall persists after reset deasserts.

## Test plan
- Forwarding: RdM=5/RegWriteM=1 and RdW=5/RegWriteW=1 with Rs1E=5 → ForwardAE=10. Drop RegWriteM → ForwardAE=01. Rs1E=0 → 00.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1 for one cycle, StallCount 0→1. Add PCSrcE=1 in the same cycle → FlushD=FlushE=1, stalls 0, RedirectCount +1.
- MUL_LAT=3: MulOpE held high → StallE=1 and FlushM=1 for 2 cycles, then 0 in the 3rd cycle. MulBusy is high in cycles 2–3. A second MulOpE immediately after repeats the same pattern.
- FORWARD_EN=0: RdM=3/RegWriteM=1, Rs1D=3 → StallF=StallD=FlushE=1 with ForwardAE=00. The same hazard on RdW → no stall.
- Counters: CNT_W=2 with stalls held 5 cycles → StallCount saturates at 3. Pulse CntClr → 0.
- Assert rst while BUSY with cnt=1 → MulBusy=0 and stalls 0 immediately. With MulOpE=0 after release, the outputs stay 0.
